sequenciador_servos: RTL and testbench
======================================

// Module: sequenciador_servos
// PURPOSE
//   Move-sequencing stage between the movement RAM and the servo PWM generators. Latches one 3-bit
//   move code, expands it into a timed sequence of target positions for base, tampa and peteleco,
//   and pulses pronto when the sequence completes. Tracks absolute base angle and flags moves that
//   would exceed the base travel limits.
// PARAMETERS
//   T_PASSO  25_000_000  clock cycles each motion step is held (0.5 s at 50 MHz); must be >= 1
//   N_T      25          width of the step timer; 2**N_T > T_PASSO
// PORTS
//   clock         in   1  system clock; sole clock domain
//   reset         in   1  asynchronous, active-low reset
//   iniciar       in   1  start request; sampled only in OCIOSO
//   move          in   3  move code, latched on the edge that accepts iniciar
//   pos_base      out  2  base target: 0=0deg, 1=90deg, 2=180deg (3 never driven)
//   tampa         out  1  1=lid closed (holds upper layers), 0=open
//   peteleco      out  1  1=flipper extended, 0=retracted
//   ocupado       out  1  high in every state except OCIOSO
//   pronto        out  1  one-cycle pulse in FIM
//   erro          out  1  set in FIM for illegal/out-of-range move; held until next accepted iniciar
//   db_estado     out  4  current state encoding, debug
// BEHAVIOUR
//   Reset (async, reset=0): state=OCIOSO, pos_base=0, tampa=0, peteleco=0, pronto=0, erro=0,
//     timer=0, latched move=000. Reset mid-sequence aborts it immediately; no pronto is issued.
//   Move codes: 000 FIM_LISTA (no motion); 001 FLIP; 010 ROT_H (cube +90, lid open);
//     011 ROT_AH (cube -90, lid open); 100 GIRO_H (bottom layer +90, lid closed);
//     101 GIRO_AH (bottom layer -90, lid closed); 110/111 illegal.
//   States: OCIOSO, DECODIFICA, PET_EMPURRA, PET_RECOLHE, TAMPA_FECHA, GIRA_BASE, TAMPA_ABRE, FIM.
//   OCIOSO: iniciar=1 at edge k -> latch move, clear erro, go DECODIFICA (cycle k+1).
//   DECODIFICA (1 cycle): 000 -> FIM; 001 -> PET_EMPURRA; 010/011 -> GIRA_BASE;
//     100/101 -> TAMPA_FECHA; 110/111 -> FIM with erro=1.
//     Range check: +90 moves (010,100) with pos_base=2, or -90 moves (011,101) with pos_base=0
//     -> FIM with erro=1, no output changes.
//   Motion states: output register updated on the entering edge; state held exactly T_PASSO cycles
//     (timer cleared on entry, exit when timer==T_PASSO-1).
//     PET_EMPURRA: peteleco<=1 -> PET_RECOLHE: peteleco<=0 -> FIM.
//     TAMPA_FECHA: tampa<=1 -> GIRA_BASE.
//     GIRA_BASE: pos_base<=pos_base+1 (H) or -1 (AH) -> TAMPA_ABRE if move[2]=1, else FIM.
//     TAMPA_ABRE: tampa<=0 -> FIM.
//   FIM (1 cycle): pronto=1 -> OCIOSO. erro stays as set.
//   Latency, iniciar accepted at edge k: pronto high in cycle k+2 (000/illegal), k+2+T_PASSO
//     (ROT), k+2+2*T_PASSO (FLIP), k+2+3*T_PASSO (GIRO).
//   iniciar while ocupado=1 is ignored (not queued); move changes after the latch edge are ignored.
//   iniciar held high through FIM re-starts the block on the edge leaving OCIOSO, i.e. one idle
//     cycle between pronto and the next DECODIFICA.
//   pos_base never leaves 0..2; tampa is 0 whenever state is OCIOSO; peteleco is 0 outside PET_EMPURRA.
// TESTING (T_PASSO=4)
//   Release reset, iniciar pulse with move=001 -> peteleco=1 for 4 cycles then 0 for 4; pronto pulse
//     10 cycles after accept edge; erro=0; pos_base stays 0.
//   move=100 from pos_base=0 -> tampa=1 (4 cyc), pos_base=1 (tampa still 1, 4 cyc), tampa=0 (4 cyc);
//     pronto at accept+14.
//   Two move=010 then a third 010 -> pos_base 1, then 2; third gives pronto at accept+2, erro=1,
//     pos_base stays 2. A following 011 clears erro and gives pos_base=1.
//   move=000 and move=111 -> pronto at accept+2, no output motion; erro=0 and 1 respectively.
//   iniciar re-pulsed mid-GIRO -> ignored, single pronto; reset=0 during TAMPA_FECHA -> tampa=0,
//     pos_base=0, ocupado=0 asynchronously, no pronto afterwards.

Source files
------------

// File: rtl/sequenciador_servos_if.sv
// Interface between the move sequencer and its surroundings.
//   master: side that issues moves (RAM reader / testbench) -- drives iniciar, move.
//   slave : the sequencer itself -- drives servo targets, status and debug.
//   iniciar    start request
//   move       3-bit move code
//   pos_base   base target (0=0deg, 1=90deg, 2=180deg)
//   tampa      lid closed when 1
//   peteleco   flipper extended when 1
//   ocupado    sequencer busy
//   pronto     one-cycle completion pulse
//   erro       last move was illegal or out of range
//   db_estado  current FSM state, debug
interface sequenciador_servos_if;
    logic       iniciar;
    logic [2:0] move;
    logic [1:0] pos_base;
    logic       tampa;
    logic       peteleco;
    logic       ocupado;
    logic       pronto;
    logic       erro;
    logic [3:0] db_estado;

    modport master (
        output iniciar, move,
        input  pos_base, tampa, peteleco, ocupado, pronto, erro, db_estado
    );

    modport slave (
        input  iniciar, move,
        output pos_base, tampa, peteleco, ocupado, pronto, erro, db_estado
    );
endinterface

// File: rtl/sequenciador_servos.sv
// Move sequencer between the movement RAM and the servo PWM generators.
// Latches a 3-bit move code, expands it into a timed sequence of base / lid / flipper
// targets, pulses pronto when done and tracks the absolute base angle, refusing moves
// that would take the base outside 0..180 degrees.
// Ports:
//   clock  system clock
//   reset  asynchronous active-low reset
//   bus    sequenciador_servos_if.slave (iniciar/move in; servo targets, status, debug out)
module sequenciador_servos #(
    parameter int unsigned T_PASSO = 25_000_000,  // cycles each motion step is held, >= 1
    parameter int unsigned N_T     = 25           // timer width, 2**N_T > T_PASSO
) (
    input  logic                 clock,
    input  logic                 reset,
    sequenciador_servos_if.slave bus
);

    typedef enum logic [3:0] {
        StOcioso     = 4'd0,
        StDecodifica = 4'd1,
        StPetEmpurra = 4'd2,
        StPetRecolhe = 4'd3,
        StTampaFecha = 4'd4,
        StGiraBase   = 4'd5,
        StTampaAbre  = 4'd6,
        StFim        = 4'd7
    } estado_e;

    estado_e          estado_q, estado_d;
    logic [2:0]       move_q, move_d;
    logic [N_T-1:0]   timer_q, timer_d;
    logic [1:0]       pos_base_q, pos_base_d;
    logic             tampa_q, tampa_d;
    logic             peteleco_q, peteleco_d;
    logic             pronto_q, pronto_d;
    logic             erro_q, erro_d;
    logic             ocupado_q, ocupado_d;

    logic             passo_fim;
    logic             em_movimento;
    logic             fora_limite;
    logic [1:0]       pos_passo;

    assign passo_fim    = (timer_q == N_T'(T_PASSO - 1));
    assign em_movimento = (estado_q == StPetEmpurra) || (estado_q == StPetRecolhe) ||
                          (estado_q == StTampaFecha) || (estado_q == StGiraBase)   ||
                          (estado_q == StTampaAbre);
    // move[0]=0 is the +90 (H) direction for both ROT and GIRO codes.
    assign fora_limite  = move_q[0] ? (pos_base_q == 2'd0) : (pos_base_q == 2'd2);
    assign pos_passo    = move_q[0] ? (pos_base_q - 2'd1) : (pos_base_q + 2'd1);

    always_comb begin
        estado_d   = estado_q;
        move_d     = move_q;
        pos_base_d = pos_base_q;
        tampa_d    = tampa_q;
        peteleco_d = peteleco_q;
        erro_d     = erro_q;

        unique case (estado_q)
            StOcioso: begin
                if (bus.iniciar) begin
                    move_d   = bus.move;
                    erro_d   = 1'b0;
                    estado_d = StDecodifica;
                end
            end
            StDecodifica: begin
                case (move_q)
                    3'b000: estado_d = StFim;
                    3'b001: begin
                        estado_d   = StPetEmpurra;
                        peteleco_d = 1'b1;
                    end
                    3'b010, 3'b011: begin
                        if (fora_limite) begin
                            estado_d = StFim;
                            erro_d   = 1'b1;
                        end else begin
                            estado_d   = StGiraBase;
                            pos_base_d = pos_passo;
                        end
                    end
                    3'b100, 3'b101: begin
                        if (fora_limite) begin
                            estado_d = StFim;
                            erro_d   = 1'b1;
                        end else begin
                            estado_d = StTampaFecha;
                            tampa_d  = 1'b1;
                        end
                    end
                    default: begin
                        estado_d = StFim;
                        erro_d   = 1'b1;
                    end
                endcase
            end
            StPetEmpurra: begin
                if (passo_fim) begin
                    estado_d   = StPetRecolhe;
                    peteleco_d = 1'b0;
                end
            end
            StPetRecolhe: begin
                if (passo_fim) estado_d = StFim;
            end
            StTampaFecha: begin
                if (passo_fim) begin
                    estado_d   = StGiraBase;
                    pos_base_d = pos_passo;
                end
            end
            StGiraBase: begin
                if (passo_fim) begin
                    if (move_q[2]) begin
                        estado_d = StTampaAbre;
                        tampa_d  = 1'b0;
                    end else begin
                        estado_d = StFim;
                    end
                end
            end
            StTampaAbre: begin
                if (passo_fim) estado_d = StFim;
            end
            StFim:   estado_d = StOcioso;
            default: estado_d = StOcioso;
        endcase

        // Timer restarts on every state entry and only runs while a step is held.
        timer_d   = (em_movimento && (estado_d == estado_q)) ? timer_q + N_T'(1) : '0;
        pronto_d  = (estado_d == StFim);
        ocupado_d = (estado_d != StOcioso);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= StOcioso;
            move_q     <= 3'b000;
            timer_q    <= '0;
            pos_base_q <= 2'd0;
            tampa_q    <= 1'b0;
            peteleco_q <= 1'b0;
            pronto_q   <= 1'b0;
            erro_q     <= 1'b0;
            ocupado_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            move_q     <= move_d;
            timer_q    <= timer_d;
            pos_base_q <= pos_base_d;
            tampa_q    <= tampa_d;
            peteleco_q <= peteleco_d;
            pronto_q   <= pronto_d;
            erro_q     <= erro_d;
            ocupado_q  <= ocupado_d;
        end
    end

    assign bus.pos_base  = pos_base_q;
    assign bus.tampa     = tampa_q;
    assign bus.peteleco  = peteleco_q;
    assign bus.pronto    = pronto_q;
    assign bus.erro      = erro_q;
    assign bus.ocupado   = ocupado_q;
    assign bus.db_estado = estado_q;

endmodule

// File: tb/tb_sequenciador_servos.sv
// Self-checking bench for sequenciador_servos with T_PASSO=4.
module tb_sequenciador_servos;

    localparam int unsigned TP = 4;

    logic clk;
    logic rst_n;

    sequenciador_servos_if bus ();

    sequenciador_servos #(
        .T_PASSO(TP),
        .N_T    (3)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [1:0] model_pos = 2'd0;

    typedef struct {
        logic [2:0] mv;
        int         lat;    // cycles from accept edge to pronto
        logic [1:0] pos;    // pos_base after the move
        logic       er;     // erro after the move
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one move, follow its output profile cycle by cycle, then check its end state.
    task automatic run_move(input logic [2:0] mv, input int lat, input logic [1:0] pos,
                            input logic er);
        logic       legal;
        logic [1:0] p0, p1;
        logic       e_pet, e_tampa;
        logic [1:0] e_pos;
        int         got_lat;
        int         bad;
        legal   = !er && (mv != 3'b000) && (mv <= 3'b101);
        p0      = model_pos;
        p1      = mv[0] ? p0 - 2'd1 : p0 + 2'd1;
        got_lat = 0;
        bad     = 0;
        bus.move    = mv;
        bus.iniciar = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.iniciar = 1'b0;
                bus.move    = ~mv;  // must be ignored once latched
            end
            e_pet   = (mv == 3'b001) && (c >= 2) && (c <= 5);
            e_tampa = legal && mv[2] && (c >= 2) && (c <= 9);
            if (legal && (mv == 3'b010 || mv == 3'b011) && c >= 2) e_pos = p1;
            else if (legal && mv[2] && c >= 6)                    e_pos = p1;
            else                                                  e_pos = p0;
            if (bus.peteleco !== e_pet || bus.tampa !== e_tampa || bus.pos_base !== e_pos)
                bad++;
            if (bus.pronto === 1'b1) begin
                got_lat = c;
                break;
            end
        end
        if (legal && mv != 3'b001) model_pos = p1;
        chk($sformatf("latency mv=%0d", mv), got_lat, lat);
        chk($sformatf("profile mv=%0d", mv), bad, 0);
        chk($sformatf("pos_base mv=%0d", mv), bus.pos_base, pos);
        chk($sformatf("erro mv=%0d", mv), bus.erro, er);
        @(negedge clk);
        chk($sformatf("idle after mv=%0d", mv), {bus.pronto, bus.ocupado, bus.db_estado},
            {1'b0, 1'b0, 4'd0});
        chk($sformatf("erro held mv=%0d", mv), bus.erro, er);
    endtask

    initial begin
        int n_pronto;
        int first_pronto;
        logic pet_seen;

        vecs[0]  = '{3'b001, 10, 2'd0, 1'b0};
        vecs[1]  = '{3'b100, 14, 2'd1, 1'b0};
        vecs[2]  = '{3'b101, 14, 2'd0, 1'b0};
        vecs[3]  = '{3'b010,  6, 2'd1, 1'b0};
        vecs[4]  = '{3'b010,  6, 2'd2, 1'b0};
        vecs[5]  = '{3'b010,  2, 2'd2, 1'b1};
        vecs[6]  = '{3'b011,  6, 2'd1, 1'b0};
        vecs[7]  = '{3'b000,  2, 2'd1, 1'b0};
        vecs[8]  = '{3'b111,  2, 2'd1, 1'b1};
        vecs[9]  = '{3'b110,  2, 2'd1, 1'b1};
        vecs[10] = '{3'b100, 14, 2'd2, 1'b0};
        vecs[11] = '{3'b100,  2, 2'd2, 1'b1};
        vecs[12] = '{3'b011,  6, 2'd1, 1'b0};
        vecs[13] = '{3'b011,  6, 2'd0, 1'b0};
        vecs[14] = '{3'b101,  2, 2'd0, 1'b1};

        rst_n       = 1'b0;
        bus.iniciar = 1'b0;
        bus.move    = 3'b000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset outputs",
            {bus.pos_base, bus.tampa, bus.peteleco, bus.pronto, bus.erro, bus.ocupado},
            {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("reset db_estado", bus.db_estado, 4'd0);

        foreach (vecs[i]) run_move(vecs[i].mv, vecs[i].lat, vecs[i].pos, vecs[i].er);

        // iniciar held high through FIM: one idle cycle, then a second DECODIFICA.
        bus.move    = 3'b000;
        bus.iniciar = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold: decodifica", bus.db_estado, 4'd1);
        @(negedge clk);
        chk("hold: first pronto", bus.pronto, 1'b1);
        @(negedge clk);
        chk("hold: idle gap", {bus.ocupado, bus.pronto, bus.db_estado}, {1'b0, 1'b0, 4'd0});
        @(negedge clk);
        chk("hold: restarted", {bus.ocupado, bus.db_estado}, {1'b1, 4'd1});
        bus.iniciar = 1'b0;
        @(negedge clk);
        chk("hold: second pronto", bus.pronto, 1'b1);
        @(negedge clk);

        // iniciar re-pulsed mid-GIRO is ignored (pos_base is 0 here).
        n_pronto     = 0;
        first_pronto = 0;
        pet_seen     = 1'b0;
        bus.move     = 3'b100;
        bus.iniciar  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (bus.pronto === 1'b1) begin
                n_pronto++;
                if (first_pronto == 0) first_pronto = c;
            end
            if (bus.peteleco === 1'b1) pet_seen = 1'b1;
            bus.iniciar = (c == 7);
            if (c == 7) bus.move = 3'b001;
        end
        chk("midgiro: pronto count", n_pronto, 1);
        chk("midgiro: pronto cycle", first_pronto, 14);
        chk("midgiro: no flip", pet_seen, 1'b0);
        chk("midgiro: pos_base", bus.pos_base, 2'd1);
        chk("midgiro: idle", bus.ocupado, 1'b0);

        // Asynchronous reset during TAMPA_FECHA.
        bus.move    = 3'b101;
        bus.iniciar = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.iniciar = 1'b0;
        @(negedge clk);
        chk("rst: tampa closed", {bus.tampa, bus.pos_base}, {1'b1, 2'd1});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst: async outputs",
            {bus.tampa, bus.pos_base, bus.ocupado, bus.pronto, bus.db_estado},
            {1'b0, 2'd0, 1'b0, 1'b0, 4'd0});
        @(negedge clk);
        rst_n    = 1'b1;
        n_pronto = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.pronto === 1'b1 || bus.ocupado === 1'b1) n_pronto++;
        end
        chk("rst: no pronto after", n_pronto, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
